// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store path: mem_op, funct3 sizes, error codes, LSU states.
// Used by the IDU, LSU and WBU so all three agree on the codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    // Sizes outside the funct3 table count as misaligned so they never reach the bus.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B, SZ_BU: misaligned = 1'b0;
            SZ_H, SZ_HU: misaligned = addr_lo[0];
            SZ_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a bus read word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    data = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   data = {24'h0, byte_sel};
            SZ_H:    data = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding bus access per EXU result, with alignment check and ack timeout.
//   state   | meaning
//   IDLE    | waiting for an EXU result (in_ready=1)
//   REQ     | bus access outstanding, mem_req=1, counting toward timeout
//   RESP    | result held on lsu_data/lsu_err until WBU takes it
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] EXU_data,
    input  logic [31:0] store_data,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_size,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] lsu_data,
    output logic [1:0]  lsu_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e         state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [2:0]         size_r;
    logic [1:0]         addr_lo_r;
    logic               we_r;
    logic               is_access, is_misaligned, timeout;
    logic [3:0]         wmask_nxt;
    logic [31:0]        wdata_nxt;
    logic [31:0]        load_data;

    lsu_load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_r),
        .size    (size_r),
        .data    (load_data)
    );

    assign in_ready      = (state == ST_IDLE);
    assign out_valid     = (state == ST_RESP);
    assign mem_req       = (state == ST_REQ);
    assign mem_we        = mem_req & we_r;
    assign is_access     = (mem_op == OP_LOAD) || (mem_op == OP_STORE);
    assign is_misaligned = misaligned(mem_size, EXU_data[1:0]);
    // The last allowed REQ cycle is the one where the count would reach TIMEOUT_CYCLES.
    assign timeout       = !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wmask_nxt = 4'b0000;
        wdata_nxt = store_data;
        if (mem_op == OP_STORE) begin
            case (mem_size)
                SZ_B, SZ_BU: begin
                    wmask_nxt = 4'b0001 << EXU_data[1:0];
                    wdata_nxt = {4{store_data[7:0]}};
                end
                SZ_H, SZ_HU: begin
                    wmask_nxt = 4'b0011 << EXU_data[1:0];
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: wmask_nxt = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = (is_access && !is_misaligned) ? ST_REQ : ST_RESP;
            ST_REQ:  if (mem_ack || timeout) state_nxt = ST_RESP;
            ST_RESP: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            size_r    <= 3'b000;
            addr_lo_r <= 2'b00;
            we_r      <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wmask <= 4'h0;
            lsu_data  <= 32'h0;
            lsu_err   <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    size_r    <= mem_size;
                    addr_lo_r <= EXU_data[1:0];
                    wait_cnt  <= '0;
                    lsu_data  <= is_access ? 32'h0 : EXU_data;
                    lsu_err   <= (is_access && is_misaligned) ? ERR_MISALIGN : ERR_OK;
                    if (is_access && !is_misaligned) begin
                        we_r      <= (mem_op == OP_STORE);
                        mem_addr  <= {EXU_data[31:2], 2'b00};
                        mem_wdata <= wdata_nxt;
                        mem_wmask <= wmask_nxt;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        lsu_data <= we_r ? 32'h0 : load_data;
                        lsu_err  <= ERR_OK;
                    end else if (timeout) begin
                        lsu_data <= 32'h0;
                        lsu_err  <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL give the maximum number of cycles spent waiting for mem_ack before the access is aborted.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EXU result valid
- in_ready  out  1  LSU can accept
- EXU_data  in  32  address, or pass-through result
- store_data  in  32  gpr rdata2
- mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- mem_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_req  out  1  bus request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  4  byte strobes
- mem_ack  in  1  bus completion
- mem_rdata  in  32  read word
- out_valid  out  1  result valid
- out_ready  in  1  WBU can accept
- lsu_data  out  32  writeback value
- lsu_err  out  2  00 ok, 01 misaligned, 10 bus timeout

Function
REQ-003 The FSM SHALL have states IDLE, REQ and RESP.
REQ-004 in_ready SHALL be 1 only in IDLE; a transfer SHALL occur when in_valid and in_ready are both high on a rising clk edge.
REQ-005 On a transfer, EXU_data, store_data, mem_op and mem_size SHALL be registered; the inputs are don't-care afterwards.
REQ-006 Accepting mem_op none SHALL go IDLE->RESP with lsu_data = the registered EXU_data and lsu_err = 00, giving out_valid 1 cycle after the transfer.
REQ-007 Misalignment SHALL be defined as H/HU with addr[0]=1, or W with addr[1:0]!=0; an unlisted mem_size on a load or store SHALL be treated as misaligned.
REQ-008 A misaligned load or store SHALL go IDLE->RESP with no bus activity, lsu_data = 0 and lsu_err = 01.
REQ-009 An aligned load or store SHALL go IDLE->REQ.
REQ-010 In REQ, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata and mem_wmask SHALL be held stable.
REQ-011 mem_addr SHALL equal {addr[31:2], 2'b00}.
REQ-012 Store data SHALL be presented as follows:
- B: wmask = 0001 << addr[1:0], wdata = the byte replicated in all four lanes.
- H: wmask = 0011 << addr[1:0], wdata = the halfword replicated in both halves.
- W: wmask = 1111.
- Loads: wmask = 0000 and mem_we = 0.
REQ-013 mem_ack sampled high in REQ SHALL end the access and go to RESP; mem_ack in any other state SHALL be ignored.
REQ-014 Load data SHALL be formed by selecting the byte or halfword at addr[1:0] from mem_rdata, then sign-extending for B/H or zero-extending for BU/HU; the result SHALL be registered as lsu_data on the ack cycle.
REQ-015 A store SHALL produce lsu_data = 0.
REQ-016 A wait counter SHALL reset to 0 on entry to REQ and increment each REQ cycle without ack.
REQ-017 When the wait counter reaches TIMEOUT_CYCLES without an ack, the FSM SHALL drop mem_req, go to RESP with lsu_data = 0 and lsu_err = 10, and SHALL NOT wait for any later ack.
REQ-018 In RESP, out_valid SHALL be 1 with lsu_data and lsu_err stable until out_ready is high.
REQ-019 out_valid and out_ready both high SHALL return the FSM to IDLE; a new transfer is possible the following cycle (no bypass).

Reset
REQ-020 rst_n low SHALL, immediately and asynchronously, force:
- state IDLE
- mem_req 0, mem_we 0
- out_valid 0
- lsu_data 0, lsu_err 00
- mem_addr, mem_wdata, mem_wmask 0
- wait counter 0
REQ-021 Reset asserted mid-access (in REQ or RESP) SHALL abandon the access with no result produced.
REQ-022 After rst_n deasserts, in_ready SHALL be 1 on the first clk edge.

Structure
REQ-023 The mem_op codes, mem_size (funct3) codes, lsu_err codes and FSM state encoding SHALL live in a shared package also used by the IDU and WBU.
REQ-024 Byte-lane extraction plus sign/zero extension SHALL be a combinational sub-module named lsu_load_align.

Verification
REQ-025 The bench SHALL cover at least these scenarios:
- Pass-through: mem_op none, EXU_data 0x1234_5678 -> out_valid 1 cycle later, lsu_data 0x1234_5678, no mem_req.
- Sign-extended byte load: LB at addr 0x8000_0003, mem_rdata 0x80FF_FFFF, ack after 3 cycles -> mem_addr 0x8000_0000, lsu_data 0xFFFF_FF80.
- Zero-extended halfword load: LHU at addr 0x8000_0002, mem_rdata 0xBEEF_0000 -> lsu_data 0x0000_BEEF.
- Halfword store: SH at 0x8000_0002, store_data 0xAAAA_1234 -> wmask 1100, wdata 0x1234_1234, mem_we 1, lsu_data 0.
- Misaligned word load: LW at 0x8000_0001 -> no mem_req, lsu_err 01; a separate access held with out_ready 0 for 5 cycles -> lsu_data stable throughout.
- Timeout: TIMEOUT_CYCLES=4 with mem_ack never asserted -> lsu_err 10 and mem_req low after 4 REQ cycles; reset asserted in REQ -> mem_req 0 immediately.
